// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the multiply/divide unit.
//   MD_WIDTH         default operand/result width
//   MD_MULT..MD_MTLO md_op encodings (6-7 are no-ops)
//   ST_IDLE/ST_BUSY  FSM state encodings
//   is_long_op()     true for ops that run through the busy counter
//   is_div_op()      true for DIV/DIVU (selects the divide latency)
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Encodings 0-3 are the multi-cycle arithmetic ops.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc -- combinational multiply/divide datapath.
//   md_op   in  3      operation select (only 0-3 produce results, others give 0)
//   A       in  WIDTH  multiplicand / dividend
//   B       in  WIDTH  multiplier / divisor
//   res_hi  out WIDTH  MULT: upper product half; DIV: remainder
//   res_lo  out WIDTH  MULT: lower product half; DIV: quotient
// Divide by zero yields lo=all ones, hi=A. The signed overflow case
// (most-negative / -1) falls out of the magnitude path as lo=A, hi=0.
import md_pkg::*;

module md_calc #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of an
  // unsigned product equal the signed product, so one multiplier serves both.
  always_comb begin
    if (md_op == MD_MULT) begin
      a_ext = {{WIDTH{A[WIDTH-1]}}, A};
      b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    end else begin
      a_ext = {{WIDTH{1'b0}}, A};
      b_ext = {{WIDTH{1'b0}}, B};
    end
  end

  assign prod = a_ext * b_ext;

  // Signed divide on magnitudes, then restore signs: quotient truncates toward
  // zero, remainder takes the dividend's sign.
  assign div_signed = (md_op == MD_DIV);
  assign a_neg      = div_signed & A[WIDTH-1];
  assign b_neg      = div_signed & B[WIDTH-1];
  assign a_mag      = a_neg ? (~A + 1'b1) : A;
  assign b_mag      = b_neg ? (~B + 1'b1) : B;
  // Keep the divider well-defined when B==0; that result is overridden below.
  assign divisor    = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag      = a_mag / divisor;
  assign r_mag      = a_mag % divisor;
  assign quot       = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (md_op == MD_MULT || md_op == MD_MULTU) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (is_div_op(md_op)) begin
      if (B == '0) begin
        res_hi = A;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers.
//   clk      in  1      rising-edge clock
//   reset_n  in  1      asynchronous active-low reset
//   start    in  1      request; md_op/A/B sampled on the same edge
//   md_op    in  3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A        in  WIDTH  rs operand
//   B        in  WIDTH  rt operand
//   cancel   in  1      (only with MD_CANCEL_EN) abort an in-flight operation
//   busy     out 1      operation in flight
//   hi       out WIDTH  HI register
//   lo       out WIDTH  LO register
// Build option: define MD_CANCEL_EN to add the cancel port. Without it,
// operations always run to completion.
// The result is computed combinationally at the start edge and parked in
// pending registers; the counter only models latency, and hi/lo update on the
// final busy edge so readers see old values for the whole busy window.
import md_pkg::*;

module md_unit #(
  parameter int WIDTH       = MD_WIDTH,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef MD_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] pend_hi_reg;
  logic [WIDTH-1:0] pend_lo_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             cancel_in;

`ifdef MD_CANCEL_EN
  assign cancel_in = cancel;
`else
  assign cancel_in = 1'b0;
`endif

  md_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      pend_hi_reg <= '0;
      pend_lo_reg <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (state_reg == ST_IDLE) begin
      // cancel on the same edge as start drops the request.
      if (start && !cancel_in) begin
        if (is_long_op(md_op)) begin
          pend_hi_reg <= res_hi;
          pend_lo_reg <= res_lo;
          cnt_reg     <= is_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
          state_reg   <= ST_BUSY;
        end else if (md_op == MD_MTHI) begin
          hi_reg <= A;
        end else if (md_op == MD_MTLO) begin
          lo_reg <= A;
        end
      end
    end else begin
      // Any start while busy is ignored; only cancel or the count matter.
      if (cancel_in) begin
        state_reg <= ST_IDLE;
      end else if (cnt_reg == '0) begin
        hi_reg    <= pend_hi_reg;
        lo_reg    <= pend_lo_reg;
        state_reg <= ST_IDLE;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  // state_reg is a flop, so busy is a registered output.
  assign busy = (state_reg == ST_BUSY);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- scoreboard bench for md_unit. Each request pushes its expected
// hi/lo and busy length; the completion monitor pops and compares.
`timescale 1ns/1ps
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
`ifdef MD_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t        sb[$];
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;
  int          n_cmp;
  int          n_bad;

  md_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .A       (A),
    .B       (B),
`ifdef MD_CANCEL_EN
    .cancel  (cancel),
`endif
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single edge and push its expectation.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int ecyc, input bit cnl);
    exp_t e;
    e.tag = tag; e.hi = eh; e.lo = el; e.cycles = ecyc;
    sb.push_back(e);
    @(negedge clk);
    prev_hi = hi;
    prev_lo = lo;
    md_op = op; A = a; B = b; start = 1'b1;
`ifdef MD_CANCEL_EN
    cancel = cnl;
`else
    if (cnl) $display("note: cancel ignored in this build");
`endif
    @(negedge clk);
    start = 1'b0;
`ifdef MD_CANCEL_EN
    cancel = 1'b0;
`endif
  endtask

  // Count busy cycles, optionally inject an MTLO at busy cycle 1 or a cancel
  // at cycle cancel_at, then pop and compare.
  task automatic wait_done(input bit inj, input int cancel_at);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == 1) check({sb[0].tag, ".hold"}, {hi, lo}, {prev_hi, prev_lo});
      start = inj && (n == 1);
      md_op = OP_MTLO;
      A     = 32'h5555_AAAA;
`ifdef MD_CANCEL_EN
      cancel = (n == cancel_at);
`else
      if (cancel_at < 0) $display("note: negative cancel index");
`endif
      @(negedge clk);
    end
    start = 1'b0;
`ifdef MD_CANCEL_EN
    cancel = 1'b0;
`endif
    if (n >= 100) check("busy_timeout", 64'(n), 64'd0);
    e = sb.pop_front();
    check({e.tag, ".cycles"}, 64'(n), 64'(e.cycles));
    check({e.tag, ".hi"}, 64'(hi), 64'(e.hi));
    check({e.tag, ".lo"}, 64'(lo), 64'(e.lo));
    $display("op %-10s cycles=%0d hi=%h lo=%h", e.tag, n, hi, lo);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc);
    issue(tag, op, a, b, eh, el, ecyc, 1'b0);
    wait_done(1'b0, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; start = 1'b0; md_op = '0; A = '0; B = '0;
`ifdef MD_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Multiply
    run_op("mult",    OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    run_op("multu",   OP_MULTU, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 5);
    run_op("mult_mn", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 5);
    // Divide
    run_op("div",     OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("divu",    OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10);
    run_op("div_nd",  OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
    run_op("divu_big",OP_DIVU,  32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 10);
    run_op("div_z",   OP_DIV,   32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 10);
    run_op("divu_z",  OP_DIVU,  32'hFFFF_ABCD, 32'd0, 32'hFFFF_ABCD, 32'hFFFF_FFFF, 10);
    run_op("div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
    // Moves and no-op
    run_op("mthi",    OP_MTHI,  32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'h8000_0000, 0);
    run_op("mtlo",    OP_MTLO,  32'h0BAD_F00D, 32'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
    run_op("nop6",    OP_NOP,   32'h1111_1111, 32'd3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
    // MTLO while busy must be ignored
    issue("mult_inj", OP_MULT, 32'd100, 32'd200, 32'h0, 32'd20000, 5, 1'b0);
    wait_done(1'b1, 0);

    // Async reset mid-operation: clears at once, no later commit.
    run_op("mthi2",   OP_MTHI,  32'hCAFE_0001, 32'd0, 32'hCAFE_0001, 32'd20000, 0);
    @(negedge clk);
    md_op = OP_DIVU; A = 32'd99; B = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.hi", 64'(hi), 64'd0);
    check("rstmid.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rstmid.late_busy", 64'(busy), 64'd0);
    check("rstmid.late_hilo", {hi, lo}, 64'd0);
    $display("op %-10s busy=%0d hi=%h lo=%h", "rst_mid", busy, hi, lo);

`ifdef MD_CANCEL_EN
    run_op("set_hi", OP_MTHI, 32'd1, 32'd0, 32'd1, 32'd0, 0);
    run_op("set_lo", OP_MTLO, 32'd1, 32'd0, 32'd1, 32'd1, 0);
    issue("mult_cnl", OP_MULT, 32'd2, 32'd3, 32'd1, 32'd1, 2, 1'b0);
    wait_done(1'b0, 2);
    issue("cnl_start", OP_MULT, 32'd2, 32'd3, 32'd1, 32'd1, 0, 1'b1);
    wait_done(1'b0, 0);
    run_op("mult_post", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 5);
`endif

    if (sb.size() != 0) check("sb.leftover", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
